// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment scan controller: snapshots a frame, then walks the
// digit slots with an all-off gap between every pair of driven digits.
module seg_scan_ctrl #(
    parameter int         DWELL_CYCLES = 50000,
    parameter int         BLANK_CYCLES = 16,
    parameter logic [6:0] MINUS_PAT    = 7'b1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [41:0] digits,
    input  logic [5:0]  point,
    input  logic        seg_en,
    input  logic        sign,
    output logic [7:0]  seg_out,
    output logic [7:0]  dig_sel,
    output logic        frame_start
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [2:0]    LAST_SLOT  = 3'd6;
    localparam logic [2:0]    SIGN_SLOT  = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [2:0]    slot;
    logic [2:0]    slot_n;
    logic [2:0]    slot_adv;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;

    logic [41:0]   snap_digits;
    logic [5:0]    snap_point;
    logic          snap_sign;
    logic          take_snap;

    logic [7:0]    slot_code;
    logic [7:0]    slot_seg;
    logic [7:0]    seg_n;
    logic [7:0]    dig_n;
    logic          fs_n;

    // Slot decode always reads the snapshot so a frame can never tear.
    always_comb begin
        slot_code = 8'hFF;
        slot_seg  = 8'h00;
        case (slot)
            3'd0: begin
                slot_code = 8'b01111111;
                slot_seg  = {snap_point[5], snap_digits[41:35]};
            end
            3'd1: begin
                slot_code = 8'b10111111;
                slot_seg  = {snap_point[4], snap_digits[34:28]};
            end
            3'd2: begin
                slot_code = 8'b11011111;
                slot_seg  = {snap_point[3], snap_digits[27:21]};
            end
            3'd3: begin
                slot_code = 8'b11101111;
                slot_seg  = {1'b0, MINUS_PAT};
            end
            3'd4: begin
                slot_code = 8'b11111011;
                slot_seg  = {snap_point[2], snap_digits[20:14]};
            end
            3'd5: begin
                slot_code = 8'b11111101;
                slot_seg  = {snap_point[1], snap_digits[13:7]};
            end
            3'd6: begin
                slot_code = 8'b11111110;
                slot_seg  = {snap_point[0], snap_digits[6:0]};
            end
            default: begin
                slot_code = 8'hFF;
                slot_seg  = 8'h00;
            end
        endcase
    end

    always_comb begin
        slot_adv = slot + 3'd1;
        if (slot == (SIGN_SLOT - 3'd1) && !snap_sign) begin
            slot_adv = SIGN_SLOT + 3'd1;
        end
    end

    // Output registers are loaded with the values for the state being entered,
    // so outputs change on the same edge as the state.
    always_comb begin
        state_n   = state;
        slot_n    = slot;
        cnt_n     = cnt;
        take_snap = 1'b0;
        fs_n      = 1'b0;
        seg_n     = 8'h00;
        dig_n     = 8'hFF;

        if (!seg_en) begin
            state_n = IDLE;
            slot_n  = 3'd0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n   = BLANK;
                    slot_n    = 3'd0;
                    cnt_n     = BLANK_LOAD;
                    take_snap = 1'b1;
                    fs_n      = 1'b1;
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_n = DRIVE;
                        cnt_n   = DWELL_LOAD;
                        dig_n   = slot_code;
                        seg_n   = slot_seg;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state_n = BLANK;
                        cnt_n   = BLANK_LOAD;
                        if (slot == LAST_SLOT) begin
                            slot_n    = 3'd0;
                            take_snap = 1'b1;
                            fs_n      = 1'b1;
                        end else begin
                            slot_n = slot_adv;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                        dig_n = slot_code;
                        seg_n = slot_seg;
                    end
                end
                default: begin
                    state_n = IDLE;
                    slot_n  = 3'd0;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= 3'd0;
            cnt         <= '0;
            snap_digits <= '0;
            snap_point  <= '0;
            snap_sign   <= 1'b0;
            seg_out     <= 8'h00;
            dig_sel     <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            cnt         <= cnt_n;
            seg_out     <= seg_n;
            dig_sel     <= dig_n;
            frame_start <= fs_n;
            if (take_snap) begin
                snap_digits <= digits;
                snap_point  <= point;
                snap_sign   <= sign;
            end
        end
    end

endmodule
